// File: rtl/pkt_fifo_pkg.sv
// Shared types and constants for the store-and-forward packet FIFO.
// Stored word layout is {last, data}.
package pkt_fifo_pkg;

  localparam int DATA_W = 8;
  localparam int WORD_W = DATA_W + 1;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register resets to zero so the FIFO head reads 0 out of reset.
module pkt_fifo_ram
  import pkt_fifo_pkg::*;
#(
  parameter int AWIDTH = 9,
  parameter int WIDTH  = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [0:(1<<AWIDTH)-1];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pkt_fifo.sv
// Store-and-forward packet FIFO with first-word-fall-through read side.
// Optional committed-packet counter enabled by defining PKT_FIFO_PKT_COUNT_EN.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int AWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              wr_ena,
  output logic              full,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ena,
  output logic              empty
`ifdef PKT_FIFO_PKT_COUNT_EN
  ,
  output logic [AWIDTH:0]   pkt_count
`endif
);

  localparam logic [AWIDTH:0] ONE        = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH:0] FULL_LEVEL = {1'b1, {AWIDTH{1'b0}}};

  logic [AWIDTH:0] wp_q, wp_d;
  logic [AWIDTH:0] cp_q, cp_d;
  logic [AWIDTH:0] rp_q, rp_d;
  logic            out_valid_q, out_valid_d;

  logic            wr_accept;
  logic            rd_accept;
  logic            fetch;
  logic [AWIDTH:0] occupancy;
  fifo_word_t      wr_word;
  fifo_word_t      head_word;
  logic [WORD_W-1:0] ram_rd_data;

  // Occupancy includes the word parked in the output register.
  assign occupancy = wp_q - rp_q + {{AWIDTH{1'b0}}, out_valid_q};
  assign full      = (occupancy == FULL_LEVEL);
  assign empty     = ~out_valid_q;

  assign wr_accept = wr_ena & ~full;
  assign rd_accept = rd_ena & out_valid_q;
  assign fetch     = (~out_valid_q | rd_accept) & (rp_q != cp_q);

  assign wr_word.last = wr_last;
  assign wr_word.data = wr_data;

  always_comb begin
    wp_d        = wp_q;
    cp_d        = cp_q;
    rp_d        = rp_q;
    out_valid_d = out_valid_q;
    if (wr_accept) begin
      wp_d = wp_q + ONE;
      if (wr_last) begin
        cp_d = wp_q + ONE;
      end
    end
    if (fetch) begin
      rp_d        = rp_q + ONE;
      out_valid_d = 1'b1;
    end else if (rd_accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q        <= '0;
      cp_q        <= '0;
      rp_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      cp_q        <= cp_d;
      rp_q        <= rp_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The RAM read register doubles as the FWFT output stage.
  pkt_fifo_ram #(
    .AWIDTH (AWIDTH),
    .WIDTH  (WORD_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wp_q[AWIDTH-1:0]),
    .wr_data (wr_word),
    .rd_en   (fetch),
    .rd_addr (rp_q[AWIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  assign head_word = fifo_word_t'(ram_rd_data);
  assign rd_data   = head_word.data;
  assign rd_last   = head_word.last;

`ifdef PKT_FIFO_PKT_COUNT_EN
  logic [AWIDTH:0] pkt_count_q, pkt_count_d;
  logic            commit;
  logic            pop_last;

  assign commit   = wr_accept & wr_last;
  assign pop_last = rd_accept & head_word.last;

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (commit && !pop_last) begin
      pkt_count_d = pkt_count_q + ONE;
    end else if (pop_last && !commit) begin
      pkt_count_d = pkt_count_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_pkt_fifo.sv
// Self-checking bench for pkt_fifo (AWIDTH=5): table vectors, directed
// sequences and randomized traffic against a queue-based reference model.
module tb_pkt_fifo;

  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;
  localparam int unsigned UNCOMMITTED = 32'hFFFF_FFFF;

  logic       clk;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       wr_ena;
  logic       full;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       rd_ena;
  logic       empty;
`ifdef PKT_FIFO_PKT_COUNT_EN
  logic [AW:0] pkt_count;
`endif

  pkt_fifo #(.AWIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_last (wr_last),
    .wr_ena  (wr_ena),
    .full    (full),
    .rd_data (rd_data),
    .rd_last (rd_last),
    .rd_ena  (rd_ena),
    .empty   (empty)
`ifdef PKT_FIFO_PKT_COUNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every word not yet popped, tagged with the edge at which
  // its packet was committed. A head word is visible after edge E iff it was
  // committed at an edge strictly before E.
  typedef struct {
    logic [7:0]  data;
    logic        last;
    int unsigned cedge;
  } mword_t;

  mword_t      mq[$];
  int unsigned edge_cnt;
  int          n_checks;
  int          n_fail;
  logic        last_wr_acc;

  typedef struct {
    logic       we;
    logic       wl;
    logic [7:0] wd;
    logic       re;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_data;
    logic       e_last;
  } vec_t;

  vec_t vt[17];

  function automatic logic model_empty();
    return !(mq.size() > 0 && mq[0].cedge < edge_cnt);
  endfunction

  function automatic int model_pkts();
    int n = 0;
    foreach (mq[i]) if (mq[i].last) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_model();
    logic e;
    e = model_empty();
    check("empty", 32'(empty), 32'(e));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    if (!e) begin
      check("rd_data", 32'(rd_data), 32'(mq[0].data));
      check("rd_last", 32'(rd_last), 32'(mq[0].last));
    end
`ifdef PKT_FIFO_PKT_COUNT_EN
    check("pkt_count", 32'(pkt_count), 32'(model_pkts()));
`endif
  endtask

  task automatic step(input logic we, input logic wl, input logic [7:0] wd, input logic re);
    logic   pre_full;
    logic   pre_empty;
    mword_t w;
    wr_ena  = we;
    wr_last = wl;
    wr_data = wd;
    rd_ena  = re;
    pre_full  = (mq.size() == DEPTH);
    pre_empty = model_empty();
    @(posedge clk);
    edge_cnt++;
    last_wr_acc = we && !pre_full;
    if (re && !pre_empty) begin
      $display("pop  data=%02h last=%b", mq[0].data, mq[0].last);
      void'(mq.pop_front());
    end
    if (last_wr_acc) begin
      w.data  = wd;
      w.last  = wl;
      w.cedge = UNCOMMITTED;
      mq.push_back(w);
      if (wl) begin
        foreach (mq[i]) if (mq[i].cedge == UNCOMMITTED) mq[i].cedge = edge_cnt;
      end
    end
    #1;
    check_model();
  endtask

  task automatic apply_reset(input int cycles);
    rst     = 1'b0;
    wr_ena  = 1'b0;
    wr_last = 1'b0;
    wr_data = 8'h00;
    rd_ena  = 1'b0;
    #1;
    mq.delete();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
    $display("reset released");
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int unsigned wr_cnt;
    int          guard;

    n_checks = 0;
    n_fail   = 0;
    edge_cnt = 0;
    rst      = 1'b0;
    wr_ena   = 1'b0;
    wr_last  = 1'b0;
    wr_data  = 8'h00;
    rd_ena   = 1'b0;

    for (int i = 0; i < 17; i++) begin
      if (i < 8) begin
        vt[i] = '{we: 1'b1, wl: (i == 7), wd: 8'(8'h40 + i), re: 1'b0,
                  e_empty: 1'b1, e_full: 1'b0, e_data: 8'h00, e_last: 1'b0};
      end else if (i == 8) begin
        vt[i] = '{we: 1'b0, wl: 1'b0, wd: 8'h00, re: 1'b0,
                  e_empty: 1'b0, e_full: 1'b0, e_data: 8'h40, e_last: 1'b0};
      end else begin
        vt[i] = '{we: 1'b0, wl: 1'b0, wd: 8'h00, re: 1'b1,
                  e_empty: (i == 16), e_full: 1'b0, e_data: 8'(8'h41 + (i - 9)),
                  e_last: (i == 15)};
      end
    end

    // Reset and idle
    apply_reset(3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);

    // Single 8-word packet, table-driven
    for (int i = 0; i < 17; i++) begin
      step(vt[i].we, vt[i].wl, vt[i].wd, vt[i].re);
      check("vec_empty", 32'(empty), 32'(vt[i].e_empty));
      check("vec_full", 32'(full), 32'(vt[i].e_full));
      if (!vt[i].e_empty) begin
        check("vec_rd_data", 32'(rd_data), 32'(vt[i].e_data));
        check("vec_rd_last", 32'(rd_last), 32'(vt[i].e_last));
      end
    end

    // Fill: 4 packets of 8, then a dropped 0x60, then read everything
    for (int i = 0; i < DEPTH; i++) step(1'b1, (i % 8) == 7, 8'(8'h80 + i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    step(1'b1, 1'b1, 8'h60, 1'b0);
    check("fill_drop", 32'(last_wr_acc), 32'd0);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    check("fill_drained", 32'(empty), 32'd1);

    // Partial packet stays invisible until its last word
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    check("partial_hidden", 32'(empty), 32'd1);
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("partial_visible", 32'(empty), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized throttled traffic, counter data in 8-word packets
    wr_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, wr_cnt[2:0] == 3'd7, wr_cnt[7:0],
           $urandom_range(0, 3) == 0);
      if (last_wr_acc) wr_cnt++;
    end
    guard = 0;
    while (wr_cnt[2:0] != 3'd0 && guard < 200) begin
      step(1'b1, wr_cnt[2:0] == 3'd7, wr_cnt[7:0], 1'b1);
      if (last_wr_acc) wr_cnt++;
      guard++;
    end
    check("rand_complete", 32'(wr_cnt[2:0]), 32'd0);
    for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    check("rand_drained", 32'(empty), 32'd1);

    // Reset mid-operation with pending words and a partial packet
    for (int i = 0; i < 3; i++) step(1'b1, i == 2, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'(8'hD0 + i), 1'b0);
    apply_reset(2);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, i == 3, 8'(8'hE0 + i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("post_rst_head", 32'(rd_data), 32'hE0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
